// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: ALU op codes (also used by the ALU), major
// opcodes, datapath defaults and the operand-select enums used by decode.
package riscv_pkg;

  localparam int WORDSIZE = 32;
  localparam int IMMSIZE  = 20;
  localparam int OPSIZE   = 4;

  localparam logic [OPSIZE-1:0] ALU_NOP = 4'd0;
  localparam logic [OPSIZE-1:0] ALU_ADD = 4'd1;
  localparam logic [OPSIZE-1:0] ALU_SUB = 4'd2;
  localparam logic [OPSIZE-1:0] ALU_SLL = 4'd3;
  localparam logic [OPSIZE-1:0] ALU_SRL = 4'd4;
  localparam logic [OPSIZE-1:0] ALU_SRA = 4'd5;
  localparam logic [OPSIZE-1:0] ALU_SLU = 4'd6;
  localparam logic [OPSIZE-1:0] ALU_SLT = 4'd7;
  localparam logic [OPSIZE-1:0] ALU_OR  = 4'd8;
  localparam logic [OPSIZE-1:0] ALU_AND = 4'd9;
  localparam logic [OPSIZE-1:0] ALU_XOR = 4'd10;
  localparam logic [OPSIZE-1:0] ALU_SIU = 4'd11;
  localparam logic [OPSIZE-1:0] ALU_AIU = 4'd12;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {ASEL_ZERO, ASEL_RS1, ASEL_PC} asel_e;
  typedef enum logic [1:0] {BSEL_IMM, BSEL_RS2, BSEL_RS2_SH} bsel_e;

endpackage

// File: rtl/id_decode.sv
// Combinational decoder for the integer-compute subset (OP-IMM, OP, LUI,
// AUIPC). Produces ALU op, immediate and operand selects; any other encoding
// is flagged illegal with op/immediate forced to zero.
module id_decode
  import riscv_pkg::*;
#(
  parameter int WORDSIZE = riscv_pkg::WORDSIZE,
  parameter int OPSIZE   = riscv_pkg::OPSIZE,
  parameter int IMMSIZE  = riscv_pkg::IMMSIZE
) (
  input  logic [31:0]         instr,
  output logic [OPSIZE-1:0]   op,
  output logic [WORDSIZE-1:0] imm,
  output asel_e               asel,
  output bsel_e               bsel,
  output logic                ill
);

  logic [6:0]          opc, f7;
  logic [2:0]          f3;
  logic [WORDSIZE-1:0] imm_i, imm_sh, imm_u;

  assign opc    = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign imm_i  = {{(WORDSIZE-12){instr[31]}}, instr[31:20]};
  assign imm_sh = {{(WORDSIZE-5){1'b0}}, instr[24:20]};
  assign imm_u  = {{(WORDSIZE-IMMSIZE){1'b0}}, instr[31:32-IMMSIZE]};

  // Decode opcode/funct fields; illegal encodings collapse to a zeroed no-op
  always_comb begin
    op   = ALU_NOP;
    imm  = '0;
    asel = ASEL_ZERO;
    bsel = BSEL_IMM;
    ill  = 1'b1;
    case (opc)
      OPC_OPIMM: begin
        ill  = 1'b0;
        asel = ASEL_RS1;
        imm  = imm_i;
        case (f3)
          3'b000: op = ALU_ADD;
          3'b010: op = ALU_SLT;
          3'b011: op = ALU_SLU;
          3'b100: op = ALU_XOR;
          3'b110: op = ALU_OR;
          3'b111: op = ALU_AND;
          3'b001: begin
            op  = ALU_SLL;
            imm = imm_sh;
            ill = (f7 != F7_BASE);
          end
          default: begin
            op  = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            imm = imm_sh;
            ill = !((f7 == F7_BASE) || (f7 == F7_ALT));
          end
        endcase
      end
      OPC_OP: begin
        ill  = 1'b0;
        asel = ASEL_RS1;
        bsel = BSEL_RS2;
        if (f7 == F7_BASE) begin
          case (f3)
            3'b000: op = ALU_ADD;
            3'b001: begin op = ALU_SLL; bsel = BSEL_RS2_SH; end
            3'b010: op = ALU_SLT;
            3'b011: op = ALU_SLU;
            3'b100: op = ALU_XOR;
            3'b101: begin op = ALU_SRL; bsel = BSEL_RS2_SH; end
            3'b110: op = ALU_OR;
            default: op = ALU_AND;
          endcase
        end else if (f7 == F7_ALT && f3 == 3'b000) begin
          op = ALU_SUB;
        end else if (f7 == F7_ALT && f3 == 3'b101) begin
          op   = ALU_SRA;
          bsel = BSEL_RS2_SH;
        end else begin
          ill = 1'b1;
        end
      end
      OPC_LUI: begin
        ill = 1'b0;
        op  = ALU_SIU;
        imm = imm_u;
      end
      OPC_AUIPC: begin
        ill  = 1'b0;
        op   = ALU_AIU;
        asel = ASEL_PC;
        imm  = imm_u;
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      op   = ALU_NOP;
      imm  = '0;
      asel = ASEL_ZERO;
      bsel = BSEL_IMM;
    end
  end

endmodule

// File: rtl/id_stage.sv
// Decode/operand stage feeding the ALU: one pipeline register behind a
// valid/ready handshake, register-file read addressing and operand muxing.
// Optional ALU-result forwarding into rs1/rs2 is enabled by defining ID_FWD_EN.
module id_stage
  import riscv_pkg::*;
#(
  parameter int WORDSIZE = riscv_pkg::WORDSIZE,
  parameter int OPSIZE   = riscv_pkg::OPSIZE,
  parameter int IMMSIZE  = riscv_pkg::IMMSIZE
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic [31:0]         INSTR,
  input  logic [WORDSIZE-1:0] PC,
  input  logic                FLUSH,
  output logic [4:0]          RS1_ADDR,
  output logic [4:0]          RS2_ADDR,
  input  logic [WORDSIZE-1:0] RS1_DATA,
  input  logic [WORDSIZE-1:0] RS2_DATA,
`ifdef ID_FWD_EN
  input  logic                FWD_WE,
  input  logic [4:0]          FWD_RD,
  input  logic [WORDSIZE-1:0] FWD_DATA,
`endif
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic [WORDSIZE-1:0] A,
  output logic [WORDSIZE-1:0] B,
  output logic [OPSIZE-1:0]   OP,
  output logic [4:0]          RD,
  output logic                WE,
  output logic                ILL
);

  logic [OPSIZE-1:0]   dec_op;
  logic [WORDSIZE-1:0] dec_imm;
  asel_e               dec_asel;
  bsel_e               dec_bsel;
  logic                dec_ill;

  id_decode #(.WORDSIZE(WORDSIZE), .OPSIZE(OPSIZE), .IMMSIZE(IMMSIZE)) u_dec (
    .instr (INSTR),
    .op    (dec_op),
    .imm   (dec_imm),
    .asel  (dec_asel),
    .bsel  (dec_bsel),
    .ill   (dec_ill)
  );

  assign RS1_ADDR = INSTR[19:15];
  assign RS2_ADDR = INSTR[24:20];

  logic [WORDSIZE-1:0] rs1_val, rs2_val;
`ifdef ID_FWD_EN
  // x0 is never forwarded; forwarded value feeds the shift mask below too
  assign rs1_val = (FWD_WE && FWD_RD != 5'd0 && FWD_RD == RS1_ADDR) ? FWD_DATA : RS1_DATA;
  assign rs2_val = (FWD_WE && FWD_RD != 5'd0 && FWD_RD == RS2_ADDR) ? FWD_DATA : RS2_DATA;
`else
  assign rs1_val = RS1_DATA;
  assign rs2_val = RS2_DATA;
`endif

  logic [WORDSIZE-1:0] a_nx, b_nx;
  logic                we_nx;

  // Operand selection; register shifts use only rs2[4:0] since the ALU shifts by all of B
  always_comb begin
    a_nx = '0;
    b_nx = '0;
    case (dec_asel)
      ASEL_RS1: a_nx = rs1_val;
      ASEL_PC:  a_nx = PC;
      default:  a_nx = '0;
    endcase
    case (dec_bsel)
      BSEL_RS2:    b_nx = rs2_val;
      BSEL_RS2_SH: b_nx = {{(WORDSIZE-5){1'b0}}, rs2_val[4:0]};
      default:     b_nx = dec_imm;
    endcase
  end

  assign we_nx = !dec_ill && (INSTR[11:7] != 5'd0);

  logic                valid_q, valid_d;
  logic [WORDSIZE-1:0] a_q, a_d, b_q, b_d;
  logic [OPSIZE-1:0]   op_q, op_d;
  logic [4:0]          rd_q, rd_d;
  logic                we_q, we_d, ill_q, ill_d;
  logic                cap;

  assign IN_READY = FLUSH | !valid_q | OUT_READY;
  assign cap      = IN_VALID & IN_READY & !FLUSH;

  // Next state: flush kills valid, stall holds it; data only changes on capture
  always_comb begin
    valid_d = !FLUSH && (cap || (valid_q && !OUT_READY));
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    rd_d    = rd_q;
    we_d    = we_q;
    ill_d   = ill_q;
    if (cap) begin
      a_d   = a_nx;
      b_d   = b_nx;
      op_d  = dec_op;
      rd_d  = INSTR[11:7];
      we_d  = we_nx;
      ill_d = dec_ill;
    end
  end

  // Pipeline register with async clear
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      ill_q   <= ill_d;
    end
  end

  assign OUT_VALID = valid_q;
  assign A         = a_q;
  assign B         = b_q;
  assign OP        = op_q;
  assign RD        = rd_q;
  assign WE        = we_q;
  assign ILL       = ill_q;

endmodule

// File: doc/id_stage.md
# id_stage

Decode/operand stage of the RV32I core; sits directly upstream of the ALU and feeds it A, B and the 4-bit ALU op code. Accepts one instruction word per beat over a valid/ready handshake, decodes the integer-compute subset (OP-IMM, OP, LUI, AUIPC), selects operands, and registers the result in a single pipeline register. The register file is external, with combinational read ports driven by this block.

## Interface
- WORDSIZE, 32: datapath width.
- OPSIZE, 4: ALU op code width.
- IMMSIZE, 20: upper-immediate width; the ALU shifts B left by WORDSIZE-IMMSIZE for SIU/AIU.
- Clock and reset: one clock, CLK; reset RST is asynchronous and active-high.
- CLK  in  1  clock.
- RST  in  1  async active-high reset.
- IN_VALID  in  1  upstream beat valid.
- IN_READY  out  1  stage can accept.
- INSTR  in  32  instruction word.
- PC  in  WORDSIZE  instruction address.
- FLUSH  in  1  discard held and incoming beat.
- RS1_ADDR / RS2_ADDR  out  5  regfile read addresses, combinational from INSTR[19:15] / INSTR[24:20].
- RS1_DATA / RS2_DATA  in  WORDSIZE  regfile read data, same cycle.
- FWD_WE, FWD_RD (5), FWD_DATA (WORDSIZE)  in  forwarding from the ALU result; present only with ID_FWD_EN.
- OUT_VALID  out  1  registered beat valid.
- OUT_READY  in  1  ALU/EX accepts.
- A, B  out  WORDSIZE  ALU operands.
- OP  out  OPSIZE  ALU op code.
- RD  out  5  destination register.
- WE  out  1  write-back enable.
- ILL  out  1  illegal/unsupported instruction.

## Operation
- ALU codes: ADD=1 SUB=2 SLL=3 SRL=4 SRA=5 SLU=6 SLT=7 OR=8 AND=9 XOR=10 SIU=11 AIU=12; 0 = no-op.
- OP-IMM (0010011): funct3 000 ADD, 010 SLT, 011 SLU, 100 XOR, 110 OR, 111 AND. B = sign-extended INSTR[31:20]. 001 SLL requires funct7=0000000; 101 requires funct7 0000000 (SRL) or 0100000 (SRA). For shifts, B = zero-extended INSTR[24:20].
- OP (0110011): funct7 0000000 maps funct3 to ADD/SLL/SLT/SLU/XOR/SRL/OR/AND. funct7 0100000 allows only 000 SUB and 101 SRA. For shifts, B = {27'b0, rs2[4:0]}, because the ALU shifts by all of B.
- LUI (0110111): OP=SIU, A=0, B={12'b0, INSTR[31:12]}.
- AUIPC (0010111): OP=AIU, A=PC, B as for LUI.
- Otherwise A = rs1 value.
- RD = INSTR[11:7]. WE = legal AND RD≠0.
- Any other opcode or funct combination: ILL=1, OP=0, A=B=0, WE=0.

## Timing
- IN_READY = FLUSH | !OUT_VALID | OUT_READY (combinational).
- Capture on the rising edge when IN_VALID & IN_READY & !FLUSH. The captured beat drives the outputs with OUT_VALID=1 in the next cycle. Latency is 1, full throughput.
- OUT_VALID & !OUT_READY: all outputs hold stable and IN_READY=0.
- Accepted with no new capture: OUT_VALID goes to 0 and the data outputs hold their last value.
- FLUSH: OUT_VALID=0 next cycle. Any input beat presented in that cycle counts as consumed and is dropped. FLUSH has priority over capture and hold.
- Reset, including mid-stall: OUT_VALID=0, A=B=0, OP=0, RD=0, WE=0, ILL=0. IN_READY=1 once RST is released.
- ILL beats still pass through the handshake; they are not dropped.

## Configuration
- ID_FWD_EN defined:
  - FWD_* ports exist.
  - If FWD_WE & FWD_RD≠0 & FWD_RD==RS1_ADDR, rs1 value = FWD_DATA; same rule for rs2.
  - Forwarding is applied before shift masking.
- ID_FWD_EN undefined: no FWD_* ports; RS1_DATA/RS2_DATA are used directly.

## Structure
- Shared package riscv_pkg:
  - ALU op code constants, shared with the ALU.
  - Opcode constants (OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC).
  - WORDSIZE/IMMSIZE defaults.
- Sub-module id_decode: purely combinational. INSTR → op, immediate, A-select (rs1/zero/PC), B-select (rs2/imm/shamt), ILL.
- id_stage: operand muxing, forwarding and the handshake register.

## Test plan
- ADDI x5,x1,-1: INSTR=0xFFF08293, RS1_DATA=0x10 → next cycle OUT_VALID=1, OP=1, A=0x10, B=0xFFFFFFFF, RD=5, WE=1.
- SRAI x3,x2,4: INSTR=0x40415193 → OP=5, B=0x4, RD=3. Same encoding with funct7=0x7F → ILL=1, OP=0, WE=0.
- LUI x1,0x12345: INSTR=0x123450B7 → OP=11, A=0, B=0x00012345. AUIPC with PC=0x100 → OP=12, A=0x100.
- Backpressure: OUT_READY=0 for 3 cycles after a capture → IN_READY=0, outputs unchanged. A FLUSH in cycle 2 → OUT_VALID=0 next cycle and IN_READY=1.
- Reset: RST asserted while stalled → all outputs 0 immediately (async). First beat after release is captured normally.
- ID_FWD_EN: ADD x2,x1,x1 (0x00108133), RS1/RS2_DATA=0x5, FWD_WE=1, FWD_RD=1, FWD_DATA=0xAA → A=B=0xAA, OP=1. With FWD_RD=0 → A=B=0x5.
